// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch definitions: FSM encodings, fetch constants and the FIFO entry layout.
package fetch_defs;
  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} fetch_state_e;

  localparam int          BYTES_PER_INST = 4;
  localparam logic [31:0] PC_STEP        = 32'h4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-stage bus: byte-wide imem port, redirect from the datapath, decode handshake.
interface inst_fetch_queue_if #(parameter int IMEM_AW = 5);
  logic [IMEM_AW-1:0] imem_addr;
  logic [7:0]         imem_rdata;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               inst_valid;
  logic [31:0]        inst;
  logic [31:0]        inst_pc;
  logic               inst_ready;

  modport master (output imem_addr, inst_valid, inst, inst_pc,
                  input  imem_rdata, redirect_valid, redirect_pc, inst_ready);
  modport slave  (input  imem_addr, inst_valid, inst, inst_pc,
                  output imem_rdata, redirect_valid, redirect_pc, inst_ready);
endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// Circular buffer of {pc, inst} entries with flush; head is read straight from storage.
module fetch_fifo
  import fetch_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_ONE = (PW+1)'(1);

  fetch_entry_t   r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PW:0]    r_count;
  logic           w_push, w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && (!o_full || w_pop);
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      // Keep the read pointer so the head outputs hold their last value.
      r_wr_ptr <= r_rd_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/inst_fetch_queue.sv
// Byte-serial instruction fetch: assembles big-endian words, tags with PC, queues for decode.
module inst_fetch_queue
  import fetch_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2,
  parameter int          IMEM_AW  = 5
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_queue_if.master  bus
);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_INST - 1);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_fetch_pc, w_fetch_pc_nxt;
  logic [1:0]   r_byte_cnt, w_byte_cnt_nxt;
  logic [23:0]  r_asm;
  logic [31:0]  r_stage;
  logic [31:0]  w_word;
  logic         w_push, w_pop, w_space, w_stage_ld, w_full, w_empty;
  fetch_entry_t w_push_data, w_head;

  assign w_word  = {r_asm, bus.imem_rdata};
  assign w_pop   = !w_empty && bus.inst_ready && !bus.redirect_valid;
  assign w_space = !w_full || w_pop;

  assign bus.imem_addr  = r_fetch_pc[IMEM_AW-1:0] + IMEM_AW'(r_byte_cnt);
  assign bus.inst_valid = !w_empty;
  assign bus.inst       = w_head.inst;
  assign bus.inst_pc    = w_head.pc;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_byte_cnt_nxt = r_byte_cnt;
    w_push         = 1'b0;
    w_stage_ld     = 1'b0;
    w_push_data    = '{pc: r_fetch_pc, inst: w_word};
    if (bus.redirect_valid) begin
      w_state_nxt    = FETCH;
      w_fetch_pc_nxt = bus.redirect_pc & ~32'h3;
      w_byte_cnt_nxt = '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (r_byte_cnt == LAST_BYTE) begin
            if (w_space) begin
              w_push         = 1'b1;
              w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
              w_byte_cnt_nxt = '0;
            end else begin
              // Byte counter stays at the last byte so imem_addr is frozen in HOLD.
              w_stage_ld  = 1'b1;
              w_state_nxt = HOLD;
            end
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          end
        end
        HOLD: begin
          w_push_data.inst = r_stage;
          if (w_space) begin
            w_push         = 1'b1;
            w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
            w_byte_cnt_nxt = '0;
            w_state_nxt    = FETCH;
          end
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH;
      r_fetch_pc <= RESET_PC & ~32'h3;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_stage    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      // Memory data is only meaningful while fetching.
      if (r_state == FETCH) r_asm <= w_word[23:0];
      if (w_stage_ld)       r_stage <= w_word;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed fetch/stall/redirect/wrap/reset scenarios.
module tb_inst_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.IMEM_AW(5)) bus();

  inst_fetch_queue #(.RESET_PC(32'h0), .DEPTH(2), .IMEM_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [32];
  assign bus.imem_rdata = mem[bus.imem_addr];

  typedef struct { logic [31:0] pc; logic [31:0] w; } exp_t;
  exp_t q[$];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Big-endian word from the bench's own memory image.
  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [4:0] a;
    a = pc[4:0];
    return {mem[a], mem[a + 5'd1], mem[a + 5'd2], mem[a + 5'd3]};
  endfunction

  task automatic expect_word(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.w  = word_at(pc);
    q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    bus.inst_ready     = rdy;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every accepted word is checked against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pop: got pc %h, no word expected", bus.inst_pc);
      end else begin
        e = q.pop_front();
        chk("pop_pc",   {32'h0, bus.inst_pc}, {32'h0, e.pc});
        chk("pop_inst", {32'h0, bus.inst},    {32'h0, e.w});
      end
    end
  end

  initial begin
    mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h04;
    for (int i = 4; i < 32; i++) mem[i] = 8'(i * 13 + 7);
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // 1: reset values, 4-cycle first-word latency, steady 1 word / 4 cycles
    rst = 1'b1;
    bus.inst_ready = 1'b1;
    tick();
    chk("rst_valid", 64'(bus.inst_valid), 64'h0);
    chk("rst_inst",  64'(bus.inst),       64'h0);
    chk("rst_pc",    64'(bus.inst_pc),    64'h0);
    chk("rst_addr",  64'(bus.imem_addr),  64'h0);
    expect_word(32'h0);
    expect_word(32'h4);
    rst = 1'b0;
    tick(3);
    chk("t1_not_yet", 64'(bus.inst_valid), 64'h0);
    tick();
    chk("t1_valid", 64'(bus.inst_valid), 64'h1);
    chk("t1_inst",  64'(bus.inst),       64'h8C010004);
    tick(4);
    chk("t1_valid2", 64'(bus.inst_valid), 64'h1);
    chk("t1_pc2",    64'(bus.inst_pc),    64'h4);
    tick();
    bus.inst_ready = 1'b0;
    chk("t1_drained", 64'(q.size()), 64'h0);

    // 2: stall until HOLD, then release and drain in order
    do_reset(1'b0);
    tick(14);
    chk("t2_hold_addr_a", 64'(bus.imem_addr), 64'hB);
    tick(6);
    chk("t2_hold_addr_b", 64'(bus.imem_addr), 64'hB);
    chk("t2_head_pc",     64'(bus.inst_pc),   64'h0);
    expect_word(32'h0);
    expect_word(32'h4);
    expect_word(32'h8);
    expect_word(32'hC);
    bus.inst_ready = 1'b1;
    tick(6);
    bus.inst_ready = 1'b0;
    chk("t2_drained", 64'(q.size()), 64'h0);

    // 3: redirect mid-word with one word buffered
    do_reset(1'b0);
    tick(6);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h13;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t3_flush_valid", 64'(bus.inst_valid), 64'h0);
    chk("t3_redir_addr",  64'(bus.imem_addr),  64'h10);
    expect_word(32'h10);
    bus.inst_ready = 1'b1;
    tick(4);
    chk("t3_new_valid", 64'(bus.inst_valid), 64'h1);
    chk("t3_new_pc",    64'(bus.inst_pc),    64'h10);
    tick();
    bus.inst_ready = 1'b0;
    chk("t3_drained", 64'(q.size()), 64'h0);

    // 4: full FIFO with push and pop on the same edge: no HOLD
    do_reset(1'b0);
    tick(11);
    expect_word(32'h0);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("t4_valid",   64'(bus.inst_valid), 64'h1);
    chk("t4_head_pc", 64'(bus.inst_pc),    64'h4);
    chk("t4_addr",    64'(bus.imem_addr),  64'hC);
    tick(4);
    chk("t4_full_hold", 64'(bus.imem_addr), 64'hF);
    tick();
    chk("t4_still_hold", 64'(bus.imem_addr), 64'hF);
    expect_word(32'h4);
    expect_word(32'h8);
    expect_word(32'hC);
    bus.inst_ready = 1'b1;
    tick(3);
    bus.inst_ready = 1'b0;
    chk("t4_drained", 64'(q.size()), 64'h0);

    // 5: memory address wraps but PC keeps counting
    do_reset(1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h1C;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t5_addr_1c", 64'(bus.imem_addr), 64'h1C);
    expect_word(32'h1C);
    q.push_back('{pc: 32'h20, w: 32'h8C010004});
    bus.inst_ready = 1'b1;
    tick(3);
    chk("t5_addr_1f", 64'(bus.imem_addr), 64'h1F);
    tick();
    chk("t5_addr_wrap", 64'(bus.imem_addr), 64'h0);
    chk("t5_pc_1c",     64'(bus.inst_pc),   64'h1C);
    tick(4);
    chk("t5_valid_20", 64'(bus.inst_valid), 64'h1);
    chk("t5_pc_20",    64'(bus.inst_pc),    64'h20);
    tick();
    bus.inst_ready = 1'b0;
    chk("t5_drained", 64'(q.size()), 64'h0);

    // 6: asynchronous reset during HOLD and mid-word
    do_reset(1'b0);
    tick(14);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", 64'(bus.inst_valid), 64'h0);
    chk("t6_async_addr",  64'(bus.imem_addr),  64'h0);
    chk("t6_async_pc",    64'(bus.inst_pc),    64'h0);
    tick();
    rst = 1'b0;
    tick(2);
    chk("t6_mid_addr", 64'(bus.imem_addr), 64'h2);
    #2 rst = 1'b1;
    #1;
    chk("t6_mid_async_addr", 64'(bus.imem_addr), 64'h0);
    tick();
    rst = 1'b0;
    tick(3);
    chk("t6_restart_wait", 64'(bus.inst_valid), 64'h0);
    tick();
    chk("t6_restart_valid", 64'(bus.inst_valid), 64'h1);
    chk("t6_restart_inst",  64'(bus.inst),       64'h8C010004);
    chk("t6_restart_pc",    64'(bus.inst_pc),    64'h0);

    tick(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
